// File: rtl/cond_unit.sv
// Condition-evaluation unit: decodes the instruction condition against the
// registered NZCV flags, gates the decoder's write/branch requests, and holds the flag register.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       stall,
  input  logic       pcs_in,
  input  logic       reg_w_in,
  input  logic       mem_w_in,
  input  logic       no_write,
  output logic       pcsrc,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags_q
);

  logic [3:0] r_flags;
  logic       w_cond_ex;
  logic       w_upd_nz;
  logic       w_upd_cv;

  // Evaluates a condition code against flags ordered {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = ~cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cy & ~z;
      4'b1001: cond_eval = ~cy | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Condition uses only the flags from before the current instruction.
  always_comb begin
    w_cond_ex = cond_eval(cond, r_flags);
    w_upd_nz  = ~stall & w_cond_ex & flag_w[1];
    w_upd_cv  = ~stall & w_cond_ex & flag_w[0];
  end

  // Flag register; stall and a failed condition both freeze it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= RESET_FLAGS;
    end else begin
      if (w_upd_nz) begin
        r_flags[3:2] <= alu_flags[3:2];
      end else begin
        r_flags[3:2] <= r_flags[3:2];
      end
      if (w_upd_cv) begin
        r_flags[1:0] <= alu_flags[1:0];
      end else begin
        r_flags[1:0] <= r_flags[1:0];
      end
    end
  end

  assign cond_ex   = w_cond_ex;
  assign pcsrc     = pcs_in & w_cond_ex;
  assign mem_write = mem_w_in & w_cond_ex;
  assign reg_write = reg_w_in & w_cond_ex & ~no_write;
  assign flags_q   = r_flags;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit with hand-computed expectations.
module tb_cond_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       stall;
  logic       pcs_in;
  logic       reg_w_in;
  logic       mem_w_in;
  logic       no_write;
  logic       pcsrc;
  logic       reg_write;
  logic       mem_write;
  logic       cond_ex;
  logic [3:0] flags_q;

  int errors = 0;
  int checks = 0;

  cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .stall     (stall),
    .pcs_in    (pcs_in),
    .reg_w_in  (reg_w_in),
    .mem_w_in  (mem_w_in),
    .no_write  (no_write),
    .pcsrc     (pcsrc),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .cond_ex   (cond_ex),
    .flags_q   (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, landing 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the flag register through an unconditional write.
  task automatic load_flags(input logic [3:0] f);
    cond = 4'b1110; flag_w = 2'b11; alu_flags = f; stall = 1'b0;
    tick();
    flag_w = 2'b00;
    check("load_flags", flags_q, f);
  endtask

  // Sweep all 16 conditions against the current flags; bit i of tbl is the answer for cond=i.
  task automatic sweep(input string tag, input logic [15:0] tbl);
    for (int i = 0; i < 16; i++) begin
      cond = i[3:0];
      #1;
      check(tag, {3'b000, cond_ex}, {3'b000, tbl[i]});
    end
  endtask

  initial begin
    rst_n = 1'b0; cond = 4'b0000; alu_flags = 4'b0000; flag_w = 2'b00; stall = 1'b0;
    pcs_in = 1'b1; reg_w_in = 1'b1; mem_w_in = 1'b1; no_write = 1'b0;
    #2;
    check("reset_flags", flags_q, 4'b0000);
    check("reset_cond_ex", {3'b000, cond_ex}, 4'b0000);
    check("reset_gated", {1'b0, pcsrc, reg_write, mem_write}, 4'b0000);
    tick();
    check("reset_hold", flags_q, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    pcs_in = 1'b0; reg_w_in = 1'b0; mem_w_in = 1'b0;

    // First edge after reset writes; new flags visible next cycle.
    cond = 4'b1110; flag_w = 2'b11; alu_flags = 4'b0110;
    #1;
    check("al_cond_ex", {3'b000, cond_ex}, 4'b0001);
    tick();
    check("first_write", flags_q, 4'b0110);
    flag_w = 2'b00; cond = 4'b0000;
    #1;
    check("eq_after_write", {3'b000, cond_ex}, 4'b0001);

    // Failed condition blocks flag update and register write.
    load_flags(4'b0000);
    cond = 4'b0000; flag_w = 2'b11; alu_flags = 4'b0100; reg_w_in = 1'b1;
    #1;
    check("eq_fail_cond_ex", {3'b000, cond_ex}, 4'b0000);
    check("eq_fail_reg_write", {3'b000, reg_write}, 4'b0000);
    tick();
    check("eq_fail_no_update", flags_q, 4'b0000);
    reg_w_in = 1'b0; flag_w = 2'b00;

    // Partial flag writes.
    cond = 4'b1110; flag_w = 2'b10; alu_flags = 4'b1111;
    tick();
    check("write_nz_only", flags_q, 4'b1100);
    flag_w = 2'b01; alu_flags = 4'b0011;
    tick();
    check("write_cv_only", flags_q, 4'b1111);
    flag_w = 2'b00; alu_flags = 4'b0000;
    tick();
    check("no_write_hold", flags_q, 4'b1111);

    // Signed compares and full decode sweeps.
    load_flags(4'b1001);
    cond = 4'b1010; #1; check("ge_1001", {3'b000, cond_ex}, 4'b0001);
    cond = 4'b1100; #1; check("gt_1001", {3'b000, cond_ex}, 4'b0001);
    cond = 4'b1101; #1; check("le_1001", {3'b000, cond_ex}, 4'b0000);
    sweep("sweep_1001", 16'b1101_0110_0101_1010);
    load_flags(4'b0110);
    sweep("sweep_0110", 16'b1110_0110_1010_0101);
    load_flags(4'b0010);
    sweep("sweep_0010", 16'b1101_0101_1010_0110);

    // Gating of pcsrc/mem_write by the condition (flags now 0010).
    pcs_in = 1'b1; mem_w_in = 1'b1; reg_w_in = 1'b1;
    cond = 4'b0000; #1;
    check("gate_fail", {1'b0, pcsrc, reg_write, mem_write}, 4'b0000);
    cond = 4'b0010; #1;
    check("gate_pass", {1'b0, pcsrc, reg_write, mem_write}, 4'b0111);

    // Stall blocks flags but not the control outputs.
    stall = 1'b1; cond = 4'b1110; flag_w = 2'b11; alu_flags = 4'b1010;
    #1;
    check("stall_outputs", {1'b0, pcsrc, reg_write, mem_write}, 4'b0111);
    tick();
    check("stall_flags_hold", flags_q, 4'b0010);
    stall = 1'b0; flag_w = 2'b00;

    // no_write suppresses only reg_write.
    no_write = 1'b1; #1;
    check("no_write_gate", {1'b0, pcsrc, reg_write, mem_write}, 4'b0101);
    no_write = 1'b0;

    // Asynchronous reset mid-cycle dominating a pending write.
    load_flags(4'b1111);
    flag_w = 2'b11; alu_flags = 4'b0101; cond = 4'b1110;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", flags_q, 4'b0000);
    tick();
    check("reset_dominates", flags_q, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_write", flags_q, 4'b0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
